// File: rtl/itch_frame_buffer.sv
// Frame buffer ahead of the order-book engine: assembles 11-word messages from a
// sop/eop word stream, queues them in a small FIFO and presents the head frame flat.
module itch_frame_buffer #(
  parameter int WORDS   = 11,
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 2,
  parameter int CW      = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [31:0]         in_data,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic                in_ready,
  input  logic                system_free,
  output logic                buffer_not_empty,
  output logic [32*WORDS-1:0] ff_buffer,
  output logic [CW-1:0]       frame_count,
  output logic [CW-1:0]       drop_count
);

  localparam int FW = 32 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int HW = $clog2(HOLDOFF + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_DISCARD
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [IW-1:0]   r_widx;
  logic [IW-1:0]   w_widxNext;
  logic [IW-1:0]   w_storeIdx;
  logic            w_store;
  logic            w_commit;
  logic [1:0]      w_dropInc;
  logic            w_accept;
  logic            w_pop;
  logic            w_bufNotEmpty;

  logic [FW-1:0]   r_mem [DEPTH];
  logic [FW-1:0]   w_wrFrame;
  logic [FW-1:0]   w_ffNext;
  logic [FW-1:0]   r_ffBuffer;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   w_headPtr;
  logic [OW-1:0]   r_occ;
  logic [OW-1:0]   w_occNext;
  logic [HW-1:0]   r_holdoff;
  logic            r_inReady;
  logic [CW-1:0]   r_frameCount;
  logic [CW-1:0]   r_dropCount;
  logic [CW:0]     w_dropSum;

  assign w_accept      = in_valid && r_inReady;
  assign w_bufNotEmpty = (r_occ != '0) && (r_holdoff == '0);
  assign w_pop         = w_bufNotEmpty && system_free;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_widx  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_widx  <= w_widxNext;
    end
  end

  // A sop word always wins: it restarts the frame in slot index 0 from any state.
  always_comb begin
    w_stateNext = r_state;
    w_widxNext  = r_widx;
    w_store     = 1'b0;
    w_storeIdx  = r_widx;
    w_commit    = 1'b0;
    w_dropInc   = 2'd0;
    if (w_accept) begin
      case (r_state)
        S_ASSEMBLE: begin
          if (in_sop) begin
            if (in_eop) begin
              w_dropInc   = 2'd2;
              w_stateNext = S_IDLE;
            end else begin
              w_dropInc   = 2'd1;
              w_store     = 1'b1;
              w_storeIdx  = '0;
              w_widxNext  = IW'(1);
            end
          end else if (r_widx == IW'(WORDS - 1)) begin
            if (in_eop) begin
              w_store     = 1'b1;
              w_commit    = 1'b1;
              w_stateNext = S_IDLE;
            end else begin
              w_dropInc   = 2'd1;
              w_stateNext = S_DISCARD;
            end
          end else if (in_eop) begin
            w_dropInc   = 2'd1;
            w_stateNext = S_IDLE;
          end else begin
            w_store    = 1'b1;
            w_widxNext = r_widx + IW'(1);
          end
        end
        default: begin
          if (in_sop) begin
            if (in_eop) begin
              w_dropInc   = 2'd1;
              w_stateNext = S_IDLE;
            end else begin
              w_store     = 1'b1;
              w_storeIdx  = '0;
              w_widxNext  = IW'(1);
              w_stateNext = S_ASSEMBLE;
            end
          end else if (r_state == S_IDLE) begin
            w_dropInc = 2'd1;
          end else if (in_eop) begin
            w_stateNext = S_IDLE;
          end
        end
      endcase
    end
  end

  // The write slot with this cycle's word merged in, so the registered head can
  // show a frame on the cycle right after it commits into an empty FIFO.
  always_comb begin
    w_wrFrame = r_mem[r_wptr];
    for (int i = 0; i < WORDS; i++) begin
      if (w_store && (w_storeIdx == IW'(i))) begin
        w_wrFrame[(WORDS-1-i)*32 +: 32] = in_data;
      end
    end
  end

  always_comb begin
    w_headPtr = w_pop ? (r_rptr + PW'(1)) : r_rptr;
    w_occNext = r_occ + OW'(w_commit) - OW'(w_pop);
    w_dropSum = {1'b0, r_dropCount} + (CW+1)'(w_dropInc);
    if (w_occNext == '0) begin
      w_ffNext = '0;
    end else if (w_headPtr == r_wptr) begin
      w_ffNext = w_wrFrame;
    end else begin
      w_ffNext = r_mem[w_headPtr];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_holdoff    <= '0;
      r_inReady    <= 1'b0;
      r_ffBuffer   <= '0;
      r_frameCount <= '0;
      r_dropCount  <= '0;
    end else begin
      if (w_store) begin
        r_mem[r_wptr] <= w_wrFrame;
      end
      if (w_commit) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + PW'(1);
        r_holdoff <= HW'(HOLDOFF);
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - HW'(1);
      end
      r_occ        <= w_occNext;
      r_inReady    <= (w_occNext < OW'(DEPTH));
      r_ffBuffer   <= w_ffNext;
      r_frameCount <= r_frameCount + CW'(w_commit);
      r_dropCount  <= w_dropSum[CW] ? '1 : w_dropSum[CW-1:0];
    end
  end

  assign in_ready         = r_inReady;
  assign buffer_not_empty = w_bufNotEmpty;
  assign ff_buffer        = r_ffBuffer;
  assign frame_count      = r_frameCount;
  assign drop_count       = r_dropCount;

endmodule

// File: doc/itch_frame_buffer.md
Name: itch_frame_buffer

Overview:
- Sits directly upstream of the order-book/top-4 engine.
- Accepts a 32-bit word stream with sop/eop framing and assembles 11-word order messages.
- Queues complete messages in a small frame FIFO and presents the head frame as a flat 352-bit ff_buffer with buffer_not_empty.
- Pops the head frame using the engine's system_free indication.

Parameters:
- WORDS, 11: words per message frame; word 0 is the first word received.
- DEPTH, 4: frame FIFO depth in frames; power of two, at least 2.
- HOLDOFF, 2: cycles buffer_not_empty is forced low after each pop.
- CW, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_data  in  32  stream word.
- in_valid  in  1  in_data is valid.
- in_sop  in  1  first word of a frame.
- in_eop  in  1  last word of a frame.
- in_ready  out  1  buffer can accept a word.
- system_free  in  1  downstream engine is idle and samples ff_buffer.
- buffer_not_empty  out  1  head frame is valid.
- ff_buffer  out  32*WORDS  head frame; word 0 in [351:320], word 10 in [31:0].
- frame_count  out  CW  frames committed; wraps.
- drop_count  out  CW  malformed frames and stray words discarded; saturates.

Behaviour:
- Reset (asynchronous, resetn=0):
  - in_ready=0, buffer_not_empty=0, ff_buffer=0, frame_count=0, drop_count=0.
  - FIFO is empty, assembler is in IDLE, holdoff counter is 0.
  - in_ready rises on the first clk edge after reset release.
  - A reset asserted mid-frame or mid-pop discards all content; no partial state survives.
- Word accept: a word is accepted only when in_valid && in_ready.
  - in_ready = (FIFO occupancy < DEPTH).
  - The assembly slot is the FIFO write slot, so the frame under assembly never overwrites stored frames.
- Assembler FSM, with word index widx (0..WORDS-1):
  - IDLE:
    - sop accepted: store the word at index 0, set widx=1, go to ASSEMBLE.
    - sop together with eop on one word: drop, drop_count+1, stay in IDLE.
    - Non-sop word: stray, drop_count+1, stay in IDLE.
  - ASSEMBLE:
    - sop accepted: the partial frame is dropped (drop_count+1) and the new word restarts the frame at index 0.
    - eop with widx < WORDS-1: drop, drop_count+1, go to IDLE.
    - widx == WORDS-1 with eop: store the word, commit the frame (occupancy+1, frame_count+1), go to IDLE.
    - widx == WORDS-1 without eop: drop, drop_count+1, go to DISCARD.
  - DISCARD:
    - Accepted words are ignored until an eop word, then go to IDLE.
    - A sop word in DISCARD restarts assembly as in IDLE; no extra count.
- Output and pop:
  - buffer_not_empty = occupancy>0 && holdoff==0.
  - ff_buffer is registered and always shows the head frame, or 0 when the FIFO is empty.
  - Pop occurs on any cycle where buffer_not_empty && system_free.
    - That cycle the engine captures ff_buffer.
    - The read pointer advances and holdoff loads HOLDOFF.
    - The holdoff gives the engine time to drop system_free so one system_free pulse can never pop twice.
  - Holdoff decrements each cycle while nonzero.
- Latency: a frame committed into an empty FIFO with holdoff==0 shows buffer_not_empty=1 and valid ff_buffer on the next cycle.
- Simultaneous commit and pop: occupancy is unchanged and both pointers advance.
  - When full, the pop frees a slot, but in_ready only reflects it on the following cycle.
- Pointers wrap modulo DEPTH.
- frame_count wraps at 2^CW; drop_count saturates at 2^CW-1.

Test Plan:
- Single frame:
  - Stimulus: system_free=0; send 11 words 0x100..0x10A with sop on the first and eop on the last.
  - Response: next cycle buffer_not_empty=1, ff_buffer[351:320]=0x100, ff_buffer[31:0]=0x10A, frame_count=1.
  - Then raise system_free: pop occurs, buffer_not_empty=0 for 2 cycles, then stays 0 (FIFO empty).
- Back-to-back fill:
  - Stimulus: 5 frames with system_free=0 and DEPTH=4.
  - Response: in_ready=0 after the 4th commit and the 5th frame is stalled.
  - Then one pop: in_ready=1 the next cycle and the 5th frame completes; heads are delivered in order 1..5.
- Short frame:
  - Stimulus: sop plus 5 words, then eop on the 6th.
  - Response: drop_count=1, frame_count=0, buffer_not_empty stays 0.
- Long frame:
  - Stimulus: 11 words with no eop, 3 more words, eop on the 14th, then a valid 11-word frame.
  - Response: drop_count=1, frame_count=1, the head equals the valid frame.
- Mid-frame sop restart and stray word:
  - Stimulus: a non-sop word in IDLE; then sop plus 3 words, then a new sop plus 10 words with eop.
  - Response: drop_count=2, frame_count=1, word 0 equals the second sop word.
- Reset and held system_free:
  - Stimulus: assert resetn=0 mid-assembly with 2 frames queued.
  - Response: all outputs 0 immediately; after release, in_ready=1 next cycle.
  - With system_free held high for 3 cycles over one queued frame, exactly one pop occurs.
